// File: rtl/pipe_pkg.sv
// Shared pipeline front-end definitions: controller state encoding, register and nop constants.
// Latency: n/a (constants and one combinational helper).
// Backpressure: n/a.
package pipe_pkg;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_FETCH_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT       = 2'd2;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'b0;

    // A load in ID/EX whose destination is read by the IF/ID instruction.
    // Writes to $zero never create a dependency.
    function automatic logic load_use(input logic       memread,
                                      input logic [4:0] ex_rt,
                                      input logic [4:0] id_rs,
                                      input logic [4:0] id_rt,
                                      input logic       uses_rt);
        return memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and holds at all-ones instead of wrapping.
// Latency: count updates one cycle after inc.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear on reset, otherwise step by one until the counter is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_id_ctrl.sv
// PC / IF-ID sequencing for the 5-stage pipeline: load-use stalls, MEM-resolved branch flushes, imem wait watchdog, halt.
// Latency: control outputs are combinational and take effect at the next clock edge; counters update one cycle later.
// Backpressure: imem_ready=0 freezes PC and IF/ID and bubbles ID/EX; a wait longer than WD_LIMIT cycles halts.
module if_id_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WD_LIMIT = 255,
    parameter int WD_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             halted,
    output logic             wd_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

    logic [1:0]      state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d, wd_inc;
    logic            wd_err_q, wd_err_d;
    logic            lu;
    logic            stall_inc, flush_inc;

    assign lu     = load_use(idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt);
    assign wd_inc = wd_q + WD_W'(1);

    // Output decode and next-state selection; a taken branch outranks every other condition.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;
        wd_d        = wd_q;
        wd_err_d    = wd_err_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc   = 1'b1;
                    if (!imem_ready) begin
                        state_d = ST_FETCH_WAIT;
                        wd_d    = '0;
                    end
                end else if (halt_req) begin
                    // The halt instruction itself moves on into ID/EX.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    state_d    = ST_HALT;
                end else if (!imem_ready) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    wd_d        = WD_W'(1);
                    state_d     = ST_FETCH_WAIT;
                end else if (lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end
            end

            ST_FETCH_WAIT: begin
                if (br_taken) begin
                    // Redirect restarts the fetch, so the wait is timed afresh.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc   = 1'b1;
                    wd_d        = '0;
                end else if (imem_ready) begin
                    wd_d    = '0;
                    state_d = ST_RUN;
                    if (lu) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                    end
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    wd_d        = wd_inc;
                    if (wd_inc >= WD_MAX) begin
                        state_d  = ST_HALT;
                        wd_err_d = 1'b1;
                    end
                end
            end

            ST_HALT: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end

            default: begin
                // Unused encoding: freeze the front end for a cycle and recover into RUN.
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                wd_d        = '0;
                state_d     = ST_RUN;
            end
        endcase

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b0;
            stall_inc   = 1'b0;
            flush_inc   = 1'b0;
        end
    end

    // State, watchdog and sticky watchdog flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wd_q     <= '0;
            wd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign halted = (state_q == ST_HALT);
    assign wd_err = wd_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed table-driven bench for if_id_ctrl with 3-bit counters and a 4-cycle watchdog.
// Latency: each vector is driven after a rising edge and checked at the following falling edge.
// Backpressure: n/a.
module tb_if_id_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       ifid_uses_rt, idex_memread, br_taken, imem_ready, halt_req;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, halted, wd_err;
    logic [2:0] stall_cnt, flush_cnt;

    if_id_ctrl #(.CNT_W(3), .WD_LIMIT(4), .WD_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .br_taken     (br_taken),
        .imem_ready   (imem_ready),
        .halt_req     (halt_req),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .exmem_flush  (exmem_flush),
        .halted       (halted),
        .wd_err       (wd_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, br, rdy, hr, mr;
        logic [4:0] xrt, rs, rt;
        logic       urt;
    } in_t;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, halted, wd_err, stall_cnt, flush_cnt}
    typedef logic [12:0] exp_t;

    typedef struct packed {
        in_t  vi;
        exp_t ve;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic in_t vin(input logic r, input logic b, input logic rd, input logic h,
                                input logic m, input logic [4:0] x, input logic [4:0] s,
                                input logic [4:0] t, input logic u);
        in_t v;
        v.rst = r; v.br = b; v.rdy = rd; v.hr = h; v.mr = m;
        v.xrt = x; v.rs = s; v.rt = t; v.urt = u;
        return v;
    endfunction

    function automatic exp_t ex(input logic pc, input logic iw, input logic ff, input logic bub,
                                input logic exf, input logic h, input logic w,
                                input int sc, input int fc);
        return {pc, iw, ff, bub, exf, h, w, 3'(sc), 3'(fc)};
    endfunction

    task automatic add(input in_t v, input exp_t e);
        vec_t r;
        r.vi = v;
        r.ve = e;
        tbl.push_back(r);
    endtask

    task automatic drive(input in_t v);
        rst          = v.rst;
        br_taken     = v.br;
        imem_ready   = v.rdy;
        halt_req     = v.hr;
        idex_memread = v.mr;
        idex_rt      = v.xrt;
        ifid_rs      = v.rs;
        ifid_rt      = v.rt;
        ifid_uses_rt = v.urt;
    endtask

    task automatic check(input string name, input int idx, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s%0d: got %b expected %b", name, idx, got, exp);
    endtask

    in_t IDLE, RST, NRDY, LU;

    initial begin
        IDLE = vin(0, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 1);
        RST  = vin(1, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 1);
        NRDY = vin(0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1);
        LU   = vin(0, 0, 1, 0, 1, 5'd8, 5'd8, 5'd2, 1);

        // reset state and plain advance
        add(RST,  ex(0,0,1,1,0, 0,0, 0,0));
        add(IDLE, ex(1,1,0,0,0, 0,0, 0,0));
        // load-use on rs: exactly one stall cycle
        add(LU,   ex(0,0,0,1,0, 0,0, 0,0));
        add(IDLE, ex(1,1,0,0,0, 0,0, 1,0));
        // load into $zero never stalls
        add(vin(0,0,1,0,1, 5'd0, 5'd0, 5'd2, 1), ex(1,1,0,0,0, 0,0, 1,0));
        // load-use through rt, only when rt is read
        add(vin(0,0,1,0,1, 5'd5, 5'd1, 5'd5, 1), ex(0,0,0,1,0, 0,0, 1,0));
        add(vin(0,0,1,0,1, 5'd5, 5'd1, 5'd5, 0), ex(1,1,0,0,0, 0,0, 2,0));
        // taken branch overrides a simultaneous load-use
        add(vin(0,1,1,0,1, 5'd8, 5'd8, 5'd2, 1), ex(1,1,1,1,1, 0,0, 2,0));
        add(IDLE, ex(1,1,0,0,0, 0,0, 2,1));
        // fetch wait of 3 cycles (kept under the 4-cycle watchdog)
        add(RST,  ex(0,0,1,1,0, 0,0, 2,1));
        add(NRDY, ex(0,0,0,1,0, 0,0, 0,0));
        add(NRDY, ex(0,0,0,1,0, 0,0, 1,0));
        add(NRDY, ex(0,0,0,1,0, 0,0, 2,0));
        add(IDLE, ex(1,1,0,0,0, 0,0, 3,0));
        add(IDLE, ex(1,1,0,0,0, 0,0, 3,0));
        // imem returns while a load-use is pending: one extra stall
        add(NRDY, ex(0,0,0,1,0, 0,0, 3,0));
        add(LU,   ex(0,0,0,1,0, 0,0, 4,0));
        add(IDLE, ex(1,1,0,0,0, 0,0, 5,0));
        // branch during fetch wait: redirect, stay waiting
        add(NRDY, ex(0,0,0,1,0, 0,0, 5,0));
        add(vin(0,1,0,0,0, 5'd0, 5'd1, 5'd2, 1), ex(1,1,1,1,1, 0,0, 6,0));
        add(NRDY, ex(0,0,0,1,0, 0,0, 6,1));
        add(IDLE, ex(1,1,0,0,0, 0,0, 7,1));
        // watchdog: 4 wait cycles then HALT with wd_err
        add(RST,  ex(0,0,1,1,0, 0,0, 7,1));
        add(NRDY, ex(0,0,0,1,0, 0,0, 0,0));
        add(NRDY, ex(0,0,0,1,0, 0,0, 1,0));
        add(NRDY, ex(0,0,0,1,0, 0,0, 2,0));
        add(NRDY, ex(0,0,0,1,0, 0,0, 3,0));
        // HALT ignores branch, halt request and load-use
        add(vin(0,1,0,0,0, 5'd0, 5'd1, 5'd2, 1), ex(0,0,0,1,0, 1,1, 4,0));
        add(vin(0,0,1,1,1, 5'd8, 5'd8, 5'd2, 1), ex(0,0,0,1,0, 1,1, 4,0));
        add(RST,  ex(0,0,1,1,0, 1,1, 4,0));
        add(IDLE, ex(1,1,0,0,0, 0,0, 0,0));
        // halt request: the halt instruction proceeds, then HALT without wd_err
        add(vin(0,0,1,1,0, 5'd0, 5'd1, 5'd2, 1), ex(0,0,0,0,0, 0,0, 0,0));
        add(IDLE, ex(0,0,0,1,0, 1,0, 0,0));
        add(RST,  ex(0,0,1,1,0, 1,0, 0,0));
        add(IDLE, ex(1,1,0,0,0, 0,0, 0,0));
        // reset in the middle of a fetch wait
        add(NRDY, ex(0,0,0,1,0, 0,0, 0,0));
        add(vin(1,0,0,0,0, 5'd0, 5'd1, 5'd2, 1), ex(0,0,1,1,0, 0,0, 1,0));
        add(IDLE, ex(1,1,0,0,0, 0,0, 0,0));

        drive(RST);
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].vi);
            @(negedge clk);
            check("vec", i, {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush,
                             halted, wd_err, stall_cnt, flush_cnt}, tbl[i].ve);
        end

        // saturation: ten back-to-back load-use stalls, counter holds at 7
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            drive(LU);
            @(negedge clk);
            check("sat_stall", k, {10'd0, pc_write, ifid_write, idex_bubble}, 13'b001);
            check("sat_cnt", k, {10'd0, stall_cnt}, {10'd0, 3'((k < 7) ? k : 7)});
        end
        @(posedge clk);
        #1;
        drive(IDLE);
        @(negedge clk);
        check("sat_final", 0, {10'd0, stall_cnt}, 13'd7);
        check("sat_adv", 0, {11'd0, pc_write, ifid_write}, 13'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_ctrl.md
Name: if_id_ctrl

Overview:
- Pipeline front-end controller for the 5-stage MIPS pipeline.
- Sequences the PC and the IF/ID register: write-enable, flush and bubble insertion.
- Detects load-use hazards and handles taken-branch redirects resolved in MEM.
- Handles instruction-memory wait states with a watchdog, a halt request, and saturating stall/flush performance counters.
- Sits between the IF stage (PC, imem) and the IF/ID and ID/EX pipeline registers.

Parameters:
- CNT_W, 16, width of the performance counters.
- WD_LIMIT, 255, maximum consecutive fetch-wait cycles before a watchdog halt.
- WD_W, 8, width of the watchdog counter (must hold WD_LIMIT).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- ifid_rs  in  5  rs field of the instruction in IF/ID.
- ifid_rt  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt  in  1  the IF/ID instruction reads rt (R-type, beq, sw).
- idex_memread  in  1  the ID/EX instruction is a load.
- idex_rt  in  5  destination rt of the ID/EX load.
- br_taken  in  1  branch taken, resolved in MEM (PCSrc).
- imem_ready  in  1  instruction memory returns a valid instr this cycle.
- halt_req  in  1  the ID stage decoded a halt instruction.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  clear IF/ID to 32'b0 (nop) at the next edge.
- idex_bubble  out  1  zero the ID/EX control bits at the next edge.
- exmem_flush  out  1  zero the EX/MEM control bits at the next edge.
- halted  out  1  the controller is in HALT.
- wd_err  out  1  HALT was entered via the watchdog; sticky until reset.
- stall_cnt  out  CNT_W  stall cycles (load-use plus fetch-wait), saturating.
- flush_cnt  out  CNT_W  taken-branch flush events, saturating.

Behaviour:
- Reset (rst=1 at posedge): state=RUN, wd counter=0, stall_cnt=0, flush_cnt=0, halted=0, wd_err=0.
- While rst=1 the control outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_flush=0.
- Control outputs are combinational from the current state and inputs, and act at the next clock edge.
- Load-use hazard (lu):
  - Condition: idex_memread & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
  - Self-clears after one cycle because the ID/EX bubble drops memread.
- States:
  - RUN:
    - Priority 1, br_taken=1: pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1; flush_cnt+1. Overrides lu and fetch-wait in the same cycle. If imem_ready=0, next state is FETCH_WAIT; otherwise stay in RUN.
    - Priority 2, halt_req=1: pc_write=0, ifid_write=0, idex_bubble=0 (the halt instruction proceeds); next state HALT.
    - Priority 3, imem_ready=0: pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt+1; wd counter=1; next state FETCH_WAIT.
    - Priority 4, lu=1: pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt+1; stay in RUN.
    - Otherwise: pc_write=1, ifid_write=1, all flush/bubble outputs 0.
  - FETCH_WAIT:
    - Outputs as in RUN priority 3, every cycle.
    - The wd counter increments each cycle.
    - br_taken still has top priority: redirect and flush as in RUN, then remain in FETCH_WAIT with the wd counter reset to 0.
    - imem_ready=1: evaluate lu as in RUN (a one-cycle stall if set, otherwise normal advance); clear the wd counter; next state RUN.
    - wd counter reaching WD_LIMIT with imem_ready=0: next state HALT, wd_err=1.
  - HALT:
    - pc_write=0, ifid_write=0, idex_bubble=1, halted=1.
    - br_taken and halt_req are ignored.
    - Only rst leaves HALT.
- Counters:
  - stall_cnt and flush_cnt hold at 2^CNT_W-1 (no wrap).
  - Counters do not increment in HALT or during reset.
- ifid_flush and ifid_write may both be 1; flush wins (IF/ID loads nop).
- Reset asserted mid-stall or mid-wait: the next cycle is RUN with all counters cleared.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding: RUN=2'd0, FETCH_WAIT=2'd1, HALT=2'd2;
  - REG_ZERO=5'd0;
  - NOP_INSTR=32'b0.
- One natural sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated for stall_cnt and flush_cnt.

Test Plan:
1. Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_cnt=1. Repeat with idex_rt=0 -> no stall.
2. Branch during load-use: br_taken=1 with lu=1 in the same cycle -> pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1; flush_cnt=1, stall_cnt unchanged.
3. Fetch wait: imem_ready=0 for 5 cycles, then 1 -> 5 stall cycles, stall_cnt=5, state returns to RUN, pc_write=1 on the ready cycle.
4. Watchdog: WD_LIMIT=4, imem_ready held at 0 -> halted=1 and wd_err=1 after 4 wait cycles; br_taken=1 afterwards has no effect; rst clears everything.
5. Saturation: CNT_W=3, 10 load-use events -> stall_cnt stays at 7.
6. Halt: halt_req=1 in RUN -> next cycle halted=1, pc_write=0; reset mid-FETCH_WAIT -> RUN, counters 0, wd_err=0.
